// File: rtl/regfile_2w2r_bypass.sv
// regfile_2w2r_bypass: parametrised register file with two write ports and
// two combinational read ports. Port B has priority over port A when both
// target the same register. Reads can forward same-cycle write data (BYPASS=1).
// Optional busy-bit scoreboard for hazard detection, enabled by defining the
// macro REGFILE_SCOREBOARD_EN; without it the sb_* / busy* ports do not exist.
// There is no valid/ready handshake anywhere: a write happens on every rising
// edge where its enable is high, and read data is valid in the same cycle.
module regfile_2w2r_bypass #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  output logic             busy1,
  output logic             busy2
`endif
);

  // An address names real, writable/readable storage: inside DEPTH and not
  // the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] rf_d [DEPTH];

  logic wr_a_ok;
  logic wr_b_ok;
  logic rd1_ok;
  logic rd2_ok;
  logic hit1_a;
  logic hit1_b;
  logic hit2_a;
  logic hit2_b;

  assign wr_a_ok = we_a && addr_ok(wa_a);
  assign wr_b_ok = we_b && addr_ok(wa_b);
  assign rd1_ok  = addr_ok(ra1);
  assign rd2_ok  = addr_ok(ra2);

  // Forwarding hits only exist when bypass is built in.
  assign hit1_a = (BYPASS != 0) && wr_a_ok && (wa_a == ra1);
  assign hit1_b = (BYPASS != 0) && wr_b_ok && (wa_b == ra1);
  assign hit2_a = (BYPASS != 0) && wr_a_ok && (wa_a == ra2);
  assign hit2_b = (BYPASS != 0) && wr_b_ok && (wa_b == ra2);

  // Next register contents: port A applied first so port B overrides it.
  always_comb begin
    rf_d = rf_q;
    if (wr_a_ok) rf_d[wa_a] = wd_a;
    if (wr_b_ok) rf_d[wa_b] = wd_b;
  end

  // Storage update; reset clears everything and discards any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read port 1: B forward, then A forward, then stored value; 0 in reset.
  always_comb begin
    rd1 = '0;
    if (reset_n && rd1_ok) begin
      if (hit1_b)      rd1 = wd_b;
      else if (hit1_a) rd1 = wd_a;
      else             rd1 = rf_q[ra1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = '0;
    if (reset_n && rd2_ok) begin
      if (hit2_b)      rd2 = wd_b;
      else if (hit2_a) rd2 = wd_a;
      else             rd2 = rf_q[ra2];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             sb_ok;

  assign sb_ok = sb_set && addr_ok(sb_addr);

  // Busy next state: completed writes retire their producer, then a new
  // issue sets the bit so a same-cycle set beats a clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_a_ok) busy_d[wa_a] = 1'b0;
    if (wr_b_ok) busy_d[wa_b] = 1'b0;
    if (sb_ok)   busy_d[sb_addr] = 1'b1;
  end

  // Busy vector state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Busy outputs; a forwarded value this cycle means the hazard is resolved.
  always_comb begin
    busy1 = reset_n && rd1_ok && busy_q[ra1] && !(hit1_a || hit1_b);
    busy2 = reset_n && rd2_ok && busy_q[ra2] && !(hit2_a || hit2_b);
  end
`endif

endmodule

// File: tb/tb_regfile_2w2r_bypass.sv
// Testbench for regfile_2w2r_bypass. Two instances share all inputs:
// dut_a uses the defaults (DEPTH=32, ZERO_REG=1, BYPASS=1), dut_b uses
// DEPTH=24, ZERO_REG=0, BYPASS=0. Scoreboard checks compile in when
// REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_2w2r_bypass;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [4:0]   ra1, ra2, wa_a, wa_b;
  logic         we_a, we_b;
  logic [W-1:0] wd_a, wd_b;
  logic [W-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
`ifdef REGFILE_SCOREBOARD_EN
  logic         sb_set;
  logic [4:0]   sb_addr;
  logic         busy1_a, busy2_a, busy1_b, busy2_b;
  logic         bz1 [32];
  logic         bz2 [24];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m1 [32];
  logic [W-1:0] m2 [24];
  logic [W-1:0] exp_q [$];

  regfile_2w2r_bypass dut_a (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b)
`ifdef REGFILE_SCOREBOARD_EN
    , .sb_set(sb_set), .sb_addr(sb_addr), .busy1(busy1_a), .busy2(busy2_a)
`endif
  );

  regfile_2w2r_bypass #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b)
`ifdef REGFILE_SCOREBOARD_EN
    , .sb_set(sb_set), .sb_addr(sb_addr), .busy1(busy1_b), .busy2(busy2_b)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] exp_rd_a(input logic [4:0] ra);
    if (!reset_n || ra == 5'd0) return '0;
    if (we_b && wa_b == ra) return wd_b;
    if (we_a && wa_a == ra) return wd_a;
    return m1[ra];
  endfunction

  function automatic logic [W-1:0] exp_rd_b(input logic [4:0] ra);
    if (!reset_n || ra >= 5'd24) return '0;
    return m2[ra];
  endfunction

`ifdef REGFILE_SCOREBOARD_EN
  function automatic logic exp_busy_a(input logic [4:0] ra);
    if (!reset_n || ra == 5'd0) return 1'b0;
    if ((we_b && wa_b == ra) || (we_a && wa_a == ra)) return 1'b0;
    return bz1[ra];
  endfunction

  function automatic logic exp_busy_b(input logic [4:0] ra);
    if (!reset_n || ra >= 5'd24) return 1'b0;
    return bz2[ra];
  endfunction
`endif

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m1[i] = '0;
    for (int i = 0; i < 24; i++) m2[i] = '0;
`ifdef REGFILE_SCOREBOARD_EN
    for (int i = 0; i < 32; i++) bz1[i] = 1'b0;
    for (int i = 0; i < 24; i++) bz2[i] = 1'b0;
`endif
  endtask

  task automatic model_edge();
    if (we_a && wa_a != 5'd0) m1[wa_a] = wd_a;
    if (we_b && wa_b != 5'd0) m1[wa_b] = wd_b;
    if (we_a && wa_a < 5'd24) m2[wa_a] = wd_a;
    if (we_b && wa_b < 5'd24) m2[wa_b] = wd_b;
`ifdef REGFILE_SCOREBOARD_EN
    if (we_a && wa_a != 5'd0) bz1[wa_a] = 1'b0;
    if (we_b && wa_b != 5'd0) bz1[wa_b] = 1'b0;
    if (sb_set && sb_addr != 5'd0) bz1[sb_addr] = 1'b1;
    if (we_a && wa_a < 5'd24) bz2[wa_a] = 1'b0;
    if (we_b && wa_b < 5'd24) bz2[wa_b] = 1'b0;
    if (sb_set && sb_addr < 5'd24) bz2[sb_addr] = 1'b1;
`endif
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    exp_q.push_back(exp_rd_a(ra1));
    exp_q.push_back(exp_rd_a(ra2));
    exp_q.push_back(exp_rd_b(ra1));
    exp_q.push_back(exp_rd_b(ra2));
    check("model_rd1_a", rd1_a, exp_q.pop_front());
    check("model_rd2_a", rd2_a, exp_q.pop_front());
    check("model_rd1_b", rd1_b, exp_q.pop_front());
    check("model_rd2_b", rd2_b, exp_q.pop_front());
`ifdef REGFILE_SCOREBOARD_EN
    check("model_busy1_a", W'(busy1_a), W'(exp_busy_a(ra1)));
    check("model_busy2_a", W'(busy2_a), W'(exp_busy_a(ra2)));
    check("model_busy1_b", W'(busy1_b), W'(exp_busy_b(ra1)));
    check("model_busy2_b", W'(busy2_b), W'(exp_busy_b(ra2)));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic i_we_a, input logic [4:0] i_wa_a, input logic [W-1:0] i_wd_a,
                       input logic i_we_b, input logic [4:0] i_wa_b, input logic [W-1:0] i_wd_b,
                       input logic [4:0] i_ra1, input logic [4:0] i_ra2);
    we_a = i_we_a; wa_a = i_wa_a; wd_a = i_wd_a;
    we_b = i_we_b; wa_b = i_wa_b; wd_b = i_wd_b;
    ra1  = i_ra1;  ra2  = i_ra2;
`ifdef REGFILE_SCOREBOARD_EN
    sb_set = 1'b0; sb_addr = 5'd0;
`endif
  endtask

  task automatic idle(input logic [4:0] i_ra1, input logic [4:0] i_ra2);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, i_ra1, i_ra2);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    check_model();
    advance();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         we_a;
    logic [4:0]   wa_a;
    logic [W-1:0] wd_a;
    logic         we_b;
    logic [4:0]   wa_b;
    logic [W-1:0] wd_b;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [W-1:0] e1a;
    logic [W-1:0] e2a;
    logic [W-1:0] e1b;
    logic [W-1:0] e2b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  32'h0,
                5'd7,  5'd3,  32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd9,  32'h00001111, 1'b1, 5'd9,  32'h00002222,
                5'd9,  5'd7,  32'h00002222, 32'h12345678, 32'h0,        32'h12345678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF,
                5'd0,  5'd9,  32'h0,        32'h00002222, 32'h0,        32'h00002222};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,
                5'd0,  5'd9,  32'h0,        32'h00002222, 32'hFFFFFFFF, 32'h00002222};
    vecs[4] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 32'hA5A5A5A5,
                5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd3,  32'h0000CAFE, 1'b0, 5'd0,  32'h0,
                5'd31, 5'd3,  32'hA5A5A5A5, 32'h0000CAFE, 32'h0,        32'h0};

    // Reset state, including a write attempted while reset is low.
    reset_n = 1'b0;
    model_reset();
    drive(1'b1, 5'd5, 32'hFFFF0000, 1'b0, 5'd0, '0, 5'd5, 5'd9);
    #2;
    check("reset_rd1_a", rd1_a, 32'h0);
    check("reset_rd2_a", rd2_a, 32'h0);
    check("reset_rd1_b", rd1_b, 32'h0);
    @(posedge clk); #1;
    check("reset_write_dropped", rd1_a, 32'h0);
    idle(5'd5, 5'd9);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("after_reset_rd1_a", rd1_a, 32'h0);
    check("after_reset_rd1_b", rd1_b, 32'h0);
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].we_a, vecs[i].wa_a, vecs[i].wd_a, vecs[i].we_b, vecs[i].wa_b, vecs[i].wd_b,
            vecs[i].ra1, vecs[i].ra2);
      settle();
      check($sformatf("vec%0d_rd1_a", i), rd1_a, vecs[i].e1a);
      check($sformatf("vec%0d_rd2_a", i), rd2_a, vecs[i].e2a);
      check($sformatf("vec%0d_rd1_b", i), rd1_b, vecs[i].e1b);
      check($sformatf("vec%0d_rd2_b", i), rd2_b, vecs[i].e2b);
      check_model();
      advance();
    end

    // Out-of-range write on the 24-entry instance: ignored, no aliasing.
    drive(1'b1, 5'd27, 32'h000000AA, 1'b0, 5'd0, '0, 5'd27, 5'd3);
    settle();
    check("oor_bypass_rd1_a", rd1_a, 32'h000000AA);
    check("oor_rd1_b", rd1_b, 32'h0);
    check("r3_visible_rd2_b", rd2_b, 32'h0000CAFE);
    check_model();
    advance();
    idle(5'd27, 5'd3);
    settle();
    check("oor_after_rd1_a", rd1_a, 32'h000000AA);
    check("oor_after_rd1_b", rd1_b, 32'h0);
    check("r3_unchanged_rd2_b", rd2_b, 32'h0000CAFE);
    check_model();
    advance();

    // Bypass vs. no-bypass latency.
    drive(1'b1, 5'd7, 32'h0BAD0BAD, 1'b0, 5'd0, '0, 5'd7, 5'd0);
    settle();
    check("bypass_rd1_a", rd1_a, 32'h0BAD0BAD);
    check("nobypass_old_rd1_b", rd1_b, 32'h12345678);
    check_model();
    advance();
    idle(5'd7, 5'd0);
    settle();
    check("nobypass_new_rd1_b", rd1_b, 32'h0BAD0BAD);
    check("r0_ordinary_rd2_b", rd2_b, 32'hFFFFFFFF);
    check_model();
    advance();

    // Reset pulsed mid-cycle after a write, and held across a write edge.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd5, 5'd5);
    step();
    idle(5'd5, 5'd6);
    settle();
    check("pre_reset_rd1_a", rd1_a, 32'hDEADBEEF);
    check("pre_reset_rd1_b", rd1_b, 32'hDEADBEEF);
    #1;
    reset_n = 1'b0;
    model_reset();
    drive(1'b1, 5'd6, 32'h00001234, 1'b0, 5'd0, '0, 5'd5, 5'd6);
    #1;
    check("midreset_rd1_a", rd1_a, 32'h0);
    check("midreset_rd1_b", rd1_b, 32'h0);
    check("midreset_bypass_rd2_a", rd2_a, 32'h0);
    @(posedge clk); #1;
    idle(5'd5, 5'd6);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("postreset_rd1_a", rd1_a, 32'h0);
    check("postreset_rd2_a", rd2_a, 32'h0);
    check("postreset_rd2_b", rd2_b, 32'h0);
    check_model();
    @(posedge clk); #1;

`ifdef REGFILE_SCOREBOARD_EN
    // Scoreboard: set, set+write (set wins), write only, idle.
    idle(5'd4, 5'd0);
    sb_set = 1'b1; sb_addr = 5'd4;
    step();
    idle(5'd4, 5'd0);
    settle();
    check("sb_set_busy1_a", W'(busy1_a), 32'h1);
    check("sb_set_busy1_b", W'(busy1_b), 32'h1);
    check("sb_r0_busy2_a", W'(busy2_a), 32'h0);
    check_model();
    advance();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, '0, 5'd4, 5'd0);
    sb_set = 1'b1; sb_addr = 5'd4;
    settle();
    check("sb_mask_busy1_a", W'(busy1_a), 32'h0);
    check("sb_nomask_busy1_b", W'(busy1_b), 32'h1);
    check_model();
    advance();
    drive(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, '0, 5'd4, 5'd0);
    settle();
    check("sb_write_mask_busy1_a", W'(busy1_a), 32'h0);
    check("sb_setwins_busy1_b", W'(busy1_b), 32'h1);
    check_model();
    advance();
    idle(5'd4, 5'd0);
    settle();
    check("sb_clear_busy1_a", W'(busy1_a), 32'h0);
    check("sb_clear_busy1_b", W'(busy1_b), 32'h0);
    check_model();
    advance();
`endif

    // Randomized traffic against the model, biased toward address collisions.
    for (int i = 0; i < 400; i++) begin
      we_a = 1'($urandom_range(0, 1));
      we_b = 1'($urandom_range(0, 1));
      wa_a = 5'($urandom_range(0, 31));
      wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 5'($urandom_range(0, 31));
      wd_a = $urandom;
      wd_b = $urandom;
      ra1  = ($urandom_range(0, 2) == 0) ? wa_a : 5'($urandom_range(0, 31));
      ra2  = ($urandom_range(0, 2) == 0) ? wa_b : 5'($urandom_range(0, 31));
`ifdef REGFILE_SCOREBOARD_EN
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = ($urandom_range(0, 2) == 0) ? wa_a : 5'($urandom_range(0, 31));
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
